// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB transmit line encoder.
// Line states, FSM encoding and the line-state to D+/D- mapping.
package usb_tx_pkg;

  localparam int STUFF_LEN_DEF = 6;
  localparam int EOP_SE0_DEF   = 2;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  // Returns {dp, dm} for a line state.
  function automatic logic [1:0] line_to_dpdm(input line_state_t ls);
    logic [1:0] dpdm;
    case (ls)
      LS_J:    dpdm = 2'b10;
      LS_K:    dpdm = 2'b01;
      default: dpdm = 2'b00;
    endcase
    return dpdm;
  endfunction

endpackage

// File: rtl/nrzi_encode.sv
// NRZI level holder: toggles J<->K on an advancing 0, holds on 1.
// SE0 overrides the drive without disturbing the held level; force_j re-arms J.
module nrzi_encode
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic advance,
  input  logic data_bit,
  input  logic force_se0,
  input  logic force_j,
  output logic dp,
  output logic dm
);

  line_state_t level_q;
  line_state_t level_d;
  line_state_t drive_d;

  always_comb begin
    level_d = level_q;
    if (force_j) begin
      level_d = LS_J;
    end else if (advance && !data_bit) begin
      if (level_q == LS_J) level_d = LS_K;
      else                 level_d = LS_J;
    end
    drive_d = force_se0 ? LS_SE0 : level_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      level_q  <= LS_J;
      {dp, dm} <= line_to_dpdm(LS_J);
    end else begin
      level_q  <= level_d;
      {dp, dm} <= line_to_dpdm(drive_d);
    end
  end

endmodule

// File: rtl/usb_bitstuff_nrzi_tx.sv
// USB full-speed transmit encoder: bit stuffing, NRZI, and EOP generation.
// Stalls the upstream serializer through in_ready during stuff and EOP cycles.
module usb_bitstuff_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LEN      = STUFF_LEN_DEF,
  parameter int EOP_SE0_CYCLES = EOP_SE0_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic out_dp,
  output logic out_dm,
  output logic out_en,
  output logic busy,
  output logic eop_done,
  output logic err_underrun
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam int SW = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES) : 1;
  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);
  localparam logic [SW-1:0] SE0_LOAD  = SW'(EOP_SE0_CYCLES - 1);

  tx_state_t       state;
  tx_state_t       next_state;
  logic [CW-1:0]   ones_cnt;
  logic [CW-1:0]   ones_inc;
  logic [SW-1:0]   se0_cnt;
  logic            last_q;
  logic            out_en_q;
  logic            eop_done_q;
  logic            accept;
  logic            hit_stuff;
  logic            enc_advance;
  logic            enc_bit;
  logic            enc_force_se0;
  logic            enc_force_j;

  assign accept    = in_valid && in_ready;
  assign ones_inc  = ones_cnt + CW'(1);
  assign hit_stuff = accept && in_bit && (ones_inc == STUFF_MAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, SEND: begin
        if (accept) begin
          if (hit_stuff)    next_state = STUFF;
          else if (in_last) next_state = EOP_SE0;
          else              next_state = SEND;
        end
      end
      STUFF:   next_state = last_q ? EOP_SE0 : SEND;
      EOP_SE0: if (se0_cnt == '0) next_state = EOP_J;
      EOP_J:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    err_underrun  = 1'b0;
    enc_advance   = 1'b0;
    enc_bit       = in_bit;
    enc_force_se0 = 1'b0;
    enc_force_j   = 1'b0;
    case (state)
      IDLE: begin
        in_ready    = 1'b1;
        enc_advance = accept;
      end
      SEND: begin
        in_ready     = 1'b1;
        enc_advance  = accept;
        err_underrun = !in_valid;
      end
      STUFF: begin
        enc_advance = 1'b1;
        enc_bit     = 1'b0;
      end
      EOP_SE0: enc_force_se0 = 1'b1;
      EOP_J:   enc_force_j   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ones_cnt   <= '0;
      last_q     <= 1'b0;
      se0_cnt    <= '0;
      out_en_q   <= 1'b0;
      eop_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, SEND: begin
          if (accept)             ones_cnt <= in_bit ? ones_inc : '0;
          else if (state == IDLE) ones_cnt <= '0;
        end
        default: ones_cnt <= '0;
      endcase
      if (hit_stuff) last_q <= in_last;
      if (state != EOP_SE0 && next_state == EOP_SE0)
        se0_cnt <= SE0_LOAD;
      else if (state == EOP_SE0 && se0_cnt != '0)
        se0_cnt <= se0_cnt - SW'(1);
      // Aligned with the line, which lags the FSM by one register stage.
      out_en_q   <= (state != IDLE) || accept;
      eop_done_q <= (state == EOP_J);
    end
  end

  assign out_en   = out_en_q;
  assign busy     = out_en_q;
  assign eop_done = eop_done_q;

  nrzi_encode u_nrzi (
    .clk       (clk),
    .rst_b     (rst_b),
    .advance   (enc_advance),
    .data_bit  (enc_bit),
    .force_se0 (enc_force_se0),
    .force_j   (enc_force_j),
    .dp        (out_dp),
    .dm        (out_dm)
  );

endmodule

// File: tb/tb_usb_bitstuff_nrzi_tx.sv
// Directed bench for usb_bitstuff_nrzi_tx with hand-computed line traces.
// Trace index c holds what is visible during cycle c (stimulus presented that cycle).
module tb_usb_bitstuff_nrzi_tx;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready, out_dp, out_dm, out_en, busy, eop_done, err_underrun;

  int checks = 0;
  int errors = 0;

  logic st_v [0:31];
  logic st_b [0:31];
  logic st_l [0:31];
  int   st_n = 0;

  logic [1:0] tr_ln   [0:31];
  logic       tr_rdy  [0:31];
  logic       tr_en   [0:31];
  logic       tr_busy [0:31];
  logic       tr_done [0:31];
  logic       tr_uerr [0:31];

  usb_bitstuff_nrzi_tx #(.STUFF_LEN(6), .EOP_SE0_CYCLES(2)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_dp       (out_dp),
    .out_dm       (out_dm),
    .out_en       (out_en),
    .busy         (busy),
    .eop_done     (eop_done),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic push(input logic v, input logic b, input logic l);
    st_v[st_n] = v;
    st_b[st_n] = b;
    st_l[st_n] = l;
    st_n++;
  endtask

  // Presents queued stimulus, advancing only when in_ready was high; records a trace.
  task automatic run_stim(input int ncyc);
    int idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (idx < st_n) begin
        in_valid = st_v[idx];
        in_bit   = st_b[idx];
        in_last  = st_l[idx];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      tr_ln[c]   = {out_dp, out_dm};
      tr_rdy[c]  = in_ready;
      tr_en[c]   = out_en;
      tr_busy[c] = busy;
      tr_done[c] = eop_done;
      tr_uerr[c] = err_underrun;
      if (in_ready && idx < st_n) idx++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    st_n     = 0;
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    #12;
    checks++;
    if ({out_dp, out_dm, out_en, busy, eop_done, err_underrun} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 100000",
               {out_dp, out_dm, out_en, busy, eop_done, err_underrun});
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || {out_dp, out_dm} !== LJ || out_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b line=%b en=%b want 1 10 0",
               in_ready, {out_dp, out_dm}, out_en);
    end
  endtask

  task automatic test_sync;
    logic [1:0] e [0:12] = '{LJ, LK, LJ, LK, LJ, LK, LJ, LK, LK, LS, LS, LJ, LJ};
    for (int i = 0; i < 8; i++) push(1'b1, (i == 7), (i == 7));
    run_stim(13);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (tr_ln[i] !== e[i]) begin
        errors++;
        $display("FAIL sync_line[%0d]: got %b want %b", i, tr_ln[i], e[i]);
      end
      checks++;
      if (tr_done[i] !== (i == 11) || tr_en[i] !== (i >= 1 && i <= 11) ||
          tr_busy[i] !== (i >= 1 && i <= 11)) begin
        errors++;
        $display("FAIL sync_ctrl[%0d]: done=%b en=%b busy=%b want %b %b %b", i,
                 tr_done[i], tr_en[i], tr_busy[i], (i == 11),
                 (i >= 1 && i <= 11), (i >= 1 && i <= 11));
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tr_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL sync_ready[%0d]: got %b want 1", i, tr_rdy[i]);
      end
    end
  endtask

  task automatic test_stuff;
    logic [1:0] e [0:14] = '{LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LK, LS, LS, LJ, LJ};
    push(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    run_stim(15);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (tr_ln[i] !== e[i] || tr_done[i] !== (i == 13)) begin
        errors++;
        $display("FAIL stuff_line[%0d]: got %b/%b want %b/%b", i, tr_ln[i],
                 tr_done[i], e[i], (i == 13));
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tr_rdy[i] !== (i != 7)) begin
        errors++;
        $display("FAIL stuff_ready[%0d]: got %b want %b", i, tr_rdy[i], (i != 7));
      end
    end
  endtask

  task automatic test_stuff_last;
    logic [1:0] e [0:12] = '{LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LS, LS, LJ, LJ};
    int ndone = 0;
    push(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) push(1'b1, 1'b1, (i == 5));
    run_stim(13);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (tr_ln[i] !== e[i]) begin
        errors++;
        $display("FAIL stuff_last_line[%0d]: got %b want %b", i, tr_ln[i], e[i]);
      end
      if (tr_done[i] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 1 || tr_done[11] !== 1'b1 || tr_en[12] !== 1'b0) begin
      errors++;
      $display("FAIL stuff_last_eop: pulses=%0d done11=%b en12=%b want 1 1 0",
               ndone, tr_done[11], tr_en[12]);
    end
  endtask

  task automatic test_twelve_ones;
    logic [1:0] e [0:19] = '{LJ, LJ, LJ, LJ, LJ, LJ, LJ, LK, LK, LK, LK, LK, LK, LK,
                             LJ, LK, LS, LS, LJ, LJ};
    for (int i = 0; i < 12; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    run_stim(20);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tr_ln[i] !== e[i] || tr_done[i] !== (i == 18)) begin
        errors++;
        $display("FAIL ones12_line[%0d]: got %b/%b want %b/%b", i, tr_ln[i],
                 tr_done[i], e[i], (i == 18));
      end
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (tr_rdy[i] !== (i != 6 && i != 13)) begin
        errors++;
        $display("FAIL ones12_ready[%0d]: got %b want %b", i, tr_rdy[i],
                 (i != 6 && i != 13));
      end
    end
  endtask

  task automatic test_underrun;
    logic [1:0] e [0:15] = '{LJ, LK, LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LK, LS, LS,
                             LJ, LJ};
    push(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    run_stim(16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tr_ln[i] !== e[i] || tr_uerr[i] !== (i == 4)) begin
        errors++;
        $display("FAIL underrun[%0d]: line=%b uerr=%b want %b %b", i, tr_ln[i],
                 tr_uerr[i], e[i], (i == 4));
      end
    end
    checks++;
    if (tr_rdy[8] !== 1'b0 || tr_done[14] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_stuff: rdy8=%b done14=%b want 0 1", tr_rdy[8], tr_done[14]);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] e [0:9] = '{LJ, LK, LS, LS, LJ, LK, LS, LS, LJ, LJ};
    push(1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b1);
    run_stim(10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tr_ln[i] !== e[i] || tr_done[i] !== (i == 4 || i == 8) ||
          tr_en[i] !== (i >= 1 && i <= 8)) begin
        errors++;
        $display("FAIL b2b[%0d]: line=%b done=%b en=%b want %b %b %b", i, tr_ln[i],
                 tr_done[i], tr_en[i], e[i], (i == 4 || i == 8), (i >= 1 && i <= 8));
      end
    end
    checks++;
    if (tr_rdy[3] !== 1'b0 || tr_rdy[4] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: rdy3=%b rdy4=%b want 0 1", tr_rdy[3], tr_rdy[4]);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] e [0:12] = '{LJ, LJ, LJ, LJ, LJ, LJ, LJ, LK, LJ, LS, LS, LJ, LJ};
    // Abort during STUFF.
    for (int i = 0; i < 7; i++) push(1'b1, 1'b1, 1'b0);
    run_stim(7);
    checks++;
    if (tr_rdy[6] !== 1'b0) begin
      errors++;
      $display("FAIL rst_stuff_state: rdy=%b want 0", tr_rdy[6]);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if ({out_dp, out_dm, out_en, busy, in_ready, eop_done} !== 6'b100010) begin
      errors++;
      $display("FAIL rst_in_stuff: got %b want 100010",
               {out_dp, out_dm, out_en, busy, in_ready, eop_done});
    end
    @(negedge clk);
    rst_b = 1'b1;
    // Abort during EOP_SE0.
    push(1'b1, 1'b0, 1'b1);
    run_stim(2);
    checks++;
    if (tr_rdy[1] !== 1'b0 || tr_ln[1] !== LK) begin
      errors++;
      $display("FAIL rst_se0_state: rdy=%b line=%b want 0 01", tr_rdy[1], tr_ln[1]);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if ({out_dp, out_dm, out_en, busy, in_ready, err_underrun} !== 6'b100010) begin
      errors++;
      $display("FAIL rst_in_se0: got %b want 100010",
               {out_dp, out_dm, out_en, busy, in_ready, err_underrun});
    end
    @(negedge clk);
    rst_b = 1'b1;
    // Fresh packet: line starts at J and the stuff lands after exactly six 1s.
    for (int i = 0; i < 6; i++) push(1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1);
    run_stim(13);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (tr_ln[i] !== e[i] || tr_done[i] !== (i == 11)) begin
        errors++;
        $display("FAIL rst_next_pkt[%0d]: got %b/%b want %b/%b", i, tr_ln[i],
                 tr_done[i], e[i], (i == 11));
      end
    end
    checks++;
    if (tr_rdy[5] !== 1'b1 || tr_rdy[6] !== 1'b0 || tr_rdy[7] !== 1'b1) begin
      errors++;
      $display("FAIL rst_next_ready: rdy5..7=%b%b%b want 101", tr_rdy[5], tr_rdy[6],
               tr_rdy[7]);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuff();
    test_stuff_last();
    test_twelve_ones();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
